// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared fetch-pipeline definitions: machine widths, controller states and a
// PC alignment helper used by the next-PC sequencer.
package fetch_pc_ctrl_pkg;

    localparam int XLEN            = 32;
    localparam int INST_BYTES      = 4;
    localparam int ALIGN_BITS      = $clog2(INST_BYTES);
    localparam int EPOCH_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    // True when the address sits on an instruction boundary.
    function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
        return (pc[ALIGN_BITS-1:0] == {ALIGN_BITS{1'b0}});
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Next-PC sequencer for the fetch stage: issues one PC beat per cycle, applies
// redirects with an epoch bump and flush pulse, honours halt and traps bad targets.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              EPOCH_W   = EPOCH_W_DEFAULT,
    parameter int              BOOT_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [EPOCH_W-1:0] epoch_o,
    input  logic               redirect_valid_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               flush_o,
    input  logic               halt_i,
    output logic               halted_o,
    output logic               fault_o,
    output logic [XLEN-1:0]    fault_pc_o
);

    localparam int                 CNT_W     = $clog2(BOOT_WAIT + 2);
    localparam logic [CNT_W-1:0]   BOOT_LAST = CNT_W'(BOOT_WAIT);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);
    localparam logic [XLEN-1:0]    PC_STEP   = XLEN'(INST_BYTES);

    fetch_state_e       state_r;
    logic [CNT_W-1:0]   boot_cnt_r;

    logic               xfer_s;
    logic               live_s;
    logic               aligned_s;
    logic               redir_ok_s;
    logic               redir_bad_s;
    logic [XLEN-1:0]    pc_inc_s;
    logic [EPOCH_W-1:0] epoch_inc_s;

    // Beat handshake, redirect classification and next-PC/epoch arithmetic.
    always_comb begin
        xfer_s      = valid_o & ready_i;
        live_s      = (state_r != FAULT);
        aligned_s   = pc_aligned(redirect_pc_i);
        redir_ok_s  = redirect_valid_i & aligned_s & live_s;
        redir_bad_s = redirect_valid_i & ~aligned_s & live_s;
        pc_inc_s    = pc_o + PC_STEP;
        epoch_inc_s = epoch_o + EPOCH_ONE;
    end

    // Controller FSM with all beat, flush, halt and fault outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BOOT;
            boot_cnt_r <= {CNT_W{1'b0}};
            valid_o    <= 1'b0;
            pc_o       <= RESET_PC;
            epoch_o    <= {EPOCH_W{1'b0}};
            flush_o    <= 1'b0;
            halted_o   <= 1'b0;
            fault_o    <= 1'b0;
            fault_pc_o <= {XLEN{1'b0}};
        end else begin
            flush_o <= redir_ok_s | redir_bad_s;
            if (redir_bad_s) begin
                // A misaligned target is fatal; epoch and PC are left as they were.
                state_r    <= FAULT;
                valid_o    <= 1'b0;
                halted_o   <= 1'b1;
                fault_o    <= 1'b1;
                fault_pc_o <= redirect_pc_i;
            end else begin
                case (state_r)
                    BOOT: begin
                        if (redir_ok_s) begin
                            pc_o    <= redirect_pc_i;
                            epoch_o <= epoch_inc_s;
                        end
                        if (boot_cnt_r == BOOT_LAST) begin
                            state_r <= RUN;
                            valid_o <= 1'b1;
                        end else begin
                            boot_cnt_r <= boot_cnt_r + CNT_ONE;
                        end
                        halted_o <= 1'b0;
                    end
                    RUN: begin
                        if (redir_ok_s) begin
                            // Redirect wins over halt: the new-PC beat is issued regardless.
                            pc_o    <= redirect_pc_i;
                            epoch_o <= epoch_inc_s;
                            valid_o <= 1'b1;
                        end else if (xfer_s) begin
                            pc_o <= pc_inc_s;
                            if (halt_i) begin
                                state_r  <= HALT;
                                valid_o  <= 1'b0;
                                halted_o <= 1'b1;
                            end else begin
                                valid_o <= 1'b1;
                            end
                        end else if (!valid_o && halt_i) begin
                            state_r  <= HALT;
                            halted_o <= 1'b1;
                        end else begin
                            valid_o <= 1'b1;
                        end
                    end
                    HALT: begin
                        if (redir_ok_s) begin
                            pc_o    <= redirect_pc_i;
                            epoch_o <= epoch_inc_s;
                        end
                        if (!halt_i) begin
                            state_r  <= RUN;
                            valid_o  <= 1'b1;
                            halted_o <= 1'b0;
                        end else begin
                            valid_o  <= 1'b0;
                            halted_o <= 1'b1;
                        end
                    end
                    FAULT: begin
                        valid_o  <= 1'b0;
                        halted_o <= 1'b1;
                    end
                    default: begin
                        state_r  <= FAULT;
                        valid_o  <= 1'b0;
                        halted_o <= 1'b1;
                        fault_o  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: hand-derived vector table, reset/boot corner sequences
// and randomized traffic compared against a cycle-level behavioural model.
module tb_fetch_pc_ctrl;

    localparam int BOOT_WAIT = 2;

    logic        clk;
    logic        rst;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [1:0]  epoch_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        flush_o;
    logic        halt_i;
    logic        halted_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;

    int checks;
    int errors;

    fetch_pc_ctrl #(
        .RESET_PC (32'h0000_0000),
        .EPOCH_W  (2),
        .BOOT_WAIT(BOOT_WAIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .pc_o            (pc_o),
        .epoch_o         (epoch_o),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .flush_o         (flush_o),
        .halt_i          (halt_i),
        .halted_o        (halted_o),
        .fault_o         (fault_o),
        .fault_pc_o      (fault_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what the outside world should see after each clock.
    bit          m_valid, m_flush, m_halted, m_fault;
    logic [31:0] m_pc, m_fault_pc;
    logic [1:0]  m_epoch;
    int          m_boot_left;
    bit          m_booting, m_halt_mode;

    task automatic model_clock(input bit r, input bit rdy, input bit hlt,
                               input bit rv, input logic [31:0] rpc);
        bit beat_taken;
        beat_taken = m_valid && rdy;
        if (r) begin
            m_valid = 0; m_pc = 32'h0; m_epoch = 2'd0; m_flush = 0;
            m_halted = 0; m_fault = 0; m_fault_pc = 32'h0;
            m_booting = 1; m_halt_mode = 0; m_boot_left = BOOT_WAIT + 1;
        end else if (m_fault) begin
            m_flush = 0;
        end else if (rv && (rpc % 4 != 0)) begin
            m_fault = 1; m_fault_pc = rpc; m_valid = 0; m_halted = 1; m_flush = 1;
            m_booting = 0; m_halt_mode = 0;
        end else begin
            m_flush = rv;
            if (rv) begin
                m_pc = rpc;
                m_epoch = (m_epoch + 2'd1) % 4;
            end
            if (m_booting) begin
                m_boot_left--;
                if (m_boot_left == 0) begin
                    m_booting = 0; m_valid = 1;
                end
            end else if (m_halt_mode) begin
                if (!hlt) begin
                    m_halt_mode = 0; m_halted = 0; m_valid = 1;
                end
            end else if (rv) begin
                m_valid = 1;
            end else if (beat_taken) begin
                m_pc = m_pc + 32'd4;
                if (hlt) begin
                    m_valid = 0; m_halt_mode = 1; m_halted = 1;
                end
            end else if (!m_valid && hlt) begin
                m_halt_mode = 1; m_halted = 1;
            end
        end
    endtask

    // Apply inputs for one cycle, advance the model, and settle past the edge.
    task automatic step(input bit r, input bit rdy, input bit hlt,
                        input bit rv, input logic [31:0] rpc);
        rst = r; ready_i = rdy; halt_i = hlt;
        redirect_valid_i = rv; redirect_pc_i = rpc;
        @(posedge clk);
        model_clock(r, rdy, hlt, rv, rpc);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst, ready, halt, rv;
        logic [31:0] rpc;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_epoch;
        bit          e_flush, e_halted, e_fault;
        logic [31:0] e_fpc;
    } vec_t;

    function automatic vec_t v(bit r, bit rdy, bit hlt, bit rv, logic [31:0] rpc,
                               bit ev, logic [31:0] epc, logic [1:0] eep,
                               bit efl, bit eh, bit ef, logic [31:0] efpc);
        vec_t t;
        t.rst = r; t.ready = rdy; t.halt = hlt; t.rv = rv; t.rpc = rpc;
        t.e_valid = ev; t.e_pc = epc; t.e_epoch = eep;
        t.e_flush = efl; t.e_halted = eh; t.e_fault = ef; t.e_fpc = efpc;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        int cyc;
        bit seen;
        checks = 0; errors = 0;
        rst = 1'b1; ready_i = 1'b0; halt_i = 1'b0;
        redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;

        //                 rst rdy hlt rv  rpc            val pc             ep fl h  f  fpc
        tbl.push_back(v(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h0,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h4,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h8,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,          1, 32'h8,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,          1, 32'h8,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,          1, 32'h8,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'hC,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h10,         0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 1, 32'h100,        1, 32'h100,        1, 1, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,          1, 32'h100,        1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h200,        1, 32'h200,        2, 1, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h300,        1, 32'h300,        3, 1, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h400,        1, 32'h400,        0, 1, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h404,        0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h20,         1, 32'h20,         1, 1, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,          1, 32'h20,         1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,          1, 32'h20,         1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,          0, 32'h24,         1, 0, 1, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,          0, 32'h24,         1, 0, 1, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h24,         1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h28,         1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 32'h102,        0, 32'h28,         1, 1, 1, 1, 32'h102));
        tbl.push_back(v(0, 1, 0, 1, 32'h200,        0, 32'h28,         1, 0, 1, 1, 32'h102));
        tbl.push_back(v(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 1, 32'hFFFF_FFF8,  0, 32'hFFFF_FFF8,  1, 1, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          0, 32'hFFFF_FFF8,  1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'hFFFF_FFF8,  1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h0,          1, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,          1, 32'h4,          1, 0, 0, 0, 32'h0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].ready, tbl[i].halt, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("vec%0d.valid", i),  {31'b0, valid_o},  {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d.pc", i),     pc_o,              tbl[i].e_pc);
            chk($sformatf("vec%0d.epoch", i),  {30'b0, epoch_o},  {30'b0, tbl[i].e_epoch});
            chk($sformatf("vec%0d.flush", i),  {31'b0, flush_o},  {31'b0, tbl[i].e_flush});
            chk($sformatf("vec%0d.halted", i), {31'b0, halted_o}, {31'b0, tbl[i].e_halted});
            chk($sformatf("vec%0d.fault", i),  {31'b0, fault_o},  {31'b0, tbl[i].e_fault});
            chk($sformatf("vec%0d.fpc", i),    fault_pc_o,        tbl[i].e_fpc);
        end

        // Reset while a beat is stalled: valid drops and PC returns home.
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        chk("rst_mid.valid", {31'b0, valid_o}, 32'd0);
        chk("rst_mid.pc", pc_o, 32'h0);

        // Boot latency measured with a bounded wait.
        cyc = 0; seen = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            step(0, 1, 0, 0, 32'h0);
            if (valid_o) begin
                seen = 1; cyc = k;
            end
        end
        chk("boot_latency", cyc, BOOT_WAIT + 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit          r, rdy, hlt, rv;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            hlt = ($urandom_range(0, 9) < 2);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            rpc[1:0] = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 15) == 0) rpc[31:4] = 28'hFFF_FFFF;
            step(r, rdy, hlt, rv, rpc);
            checks++;
            if (valid_o !== m_valid || pc_o !== m_pc || epoch_o !== m_epoch ||
                flush_o !== m_flush || halted_o !== m_halted || fault_o !== m_fault ||
                fault_pc_o !== m_fault_pc) begin
                errors++;
                $display("FAIL rand%0d: got v%b pc%h ep%0d fl%b h%b f%b fpc%h expected v%b pc%h ep%0d fl%b h%b f%b fpc%h",
                         n, valid_o, pc_o, epoch_o, flush_o, halted_o, fault_o, fault_pc_o,
                         m_valid, m_pc, m_epoch, m_flush, m_halted, m_fault, m_fault_pc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
